// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the layout of one program entry.
package alu_pkg;

    localparam int OP_W    = 4;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = OP_W + DATA_W;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h2;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h3;
    localparam logic [OP_W-1:0] OP_ROL  = 4'h4;
    localparam logic [OP_W-1:0] OP_ROR  = 4'h5;
    localparam logic [OP_W-1:0] OP_AND  = 4'h6;
    localparam logic [OP_W-1:0] OP_OR   = 4'h7;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
    localparam logic [OP_W-1:0] OP_NAND = 4'h9;
    localparam logic [OP_W-1:0] OP_NOR  = 4'hA;
    localparam logic [OP_W-1:0] OP_NOT  = 4'hB;
    localparam logic [OP_W-1:0] OP_INC  = 4'hC;
    localparam logic [OP_W-1:0] OP_NOP  = 4'hD;
    localparam logic [OP_W-1:0] OP_HOLD = 4'hE;
    localparam logic [OP_W-1:0] OP_LOAD = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EXEC,
        CAPTURE,
        NEXT,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } prog_entry_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/result bus between the sequencer (master) and the ALU core (slave).
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic [OP_W-1:0]   alu_op_sel;
    logic [DATA_W-1:0] alu_input_bits;
    logic              alu_exec;
    logic [DATA_W-1:0] alu_y;

    modport master (
        output alu_op_sel,
        output alu_input_bits,
        output alu_exec,
        input  alu_y
    );

    modport slave (
        input  alu_op_sel,
        input  alu_input_bits,
        input  alu_exec,
        output alu_y
    );
endinterface

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH entries of {op, data}, one synchronous write port and
// one asynchronous read port.
module seq_prog_mem
    import alu_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        we,
    input  logic [AW-1:0] waddr,
    input  prog_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output prog_entry_t rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a reset would turn it into flops with a
    // huge reset fan-out, and every entry is written before it is ever run.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues a stored program of {op, data} entries to the ALU, strobing exec
// once per entry and capturing the ALU result after each strobe.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int SETTLE  = 2,
    parameter  int CAP_LAT = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [OP_W-1:0]   prog_op,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [AW:0]       prog_len,
    alu_op_sequencer_if.master alu,
    output logic [AW-1:0]     pc,
    output logic [DATA_W-1:0] last_y,
    output logic              result_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (SETTLE > CAP_LAT) ? SETTLE : CAP_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    seq_state_e    state, state_d;
    logic          start_q, start_qq, start_rise;
    logic [AW:0]   len_q, len_d, len_clamped;
    logic [AW-1:0] pc_d, rd_addr;
    logic [CW-1:0] cnt;
    logic          load_cmd, capture, last_entry;
    prog_entry_t   rd_entry, cmd_q;

    seq_prog_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (prog_we && (state == IDLE)),
        .waddr (prog_addr),
        .wdata ({prog_op, prog_data}),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    assign start_rise  = start_q && !start_qq;
    assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign last_entry  = ({1'b0, pc} == (len_q - (AW+1)'(1)));

    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        len_d    = len_q;
        rd_addr  = pc;
        load_cmd = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                rd_addr = '0;
                if (start_rise && !abort) begin
                    len_d = len_clamped;
                    pc_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SETUP;
                        load_cmd = 1'b1;
                    end
                end
            end
            SETUP:   if (cnt == CW'(SETTLE - 1)) state_d = EXEC;
            EXEC:    state_d = CAPTURE;
            CAPTURE: begin
                if (cnt == CW'(CAP_LAT - 1)) begin
                    state_d = NEXT;
                    capture = 1'b1;
                end
            end
            NEXT: begin
                if (last_entry) begin
                    state_d = DONE;
                end else begin
                    pc_d     = pc + AW'(1);
                    rd_addr  = pc + AW'(1);
                    load_cmd = 1'b1;
                    state_d  = SETUP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort beats everything: no new command, no capture, pc frozen.
        if (abort && (state != IDLE)) begin
            state_d  = IDLE;
            pc_d     = pc;
            load_cmd = 1'b0;
            capture  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            start_qq     <= 1'b0;
            len_q        <= '0;
            pc           <= '0;
            cnt          <= '0;
            cmd_q        <= '0;
            last_y       <= '0;
            result_valid <= 1'b0;
        end else begin
            start_q      <= start;
            start_qq     <= start_q;
            len_q        <= len_d;
            pc           <= pc_d;
            result_valid <= capture;
            if (state_d != state) begin
                cnt <= '0;
            end else if ((state == SETUP) || (state == CAPTURE)) begin
                cnt <= cnt + CW'(1);
            end
            if (load_cmd) begin
                cmd_q <= rd_entry;
            end
            if (capture) begin
                last_y <= alu.alu_y;
            end
        end
    end

    assign alu.alu_op_sel     = cmd_q.op;
    assign alu.alu_input_bits = cmd_q.data;
    assign alu.alu_exec       = (state == EXEC) && !abort;
    assign busy               = (state != IDLE);
    assign done               = (state == DONE) && !abort;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural A/Y ALU model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [3:0]    prog_op = '0;
    logic [7:0]    prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic [AW-1:0] pc;
    logic [7:0]    last_y;
    logic          result_valid, busy, done;

    alu_op_sequencer_if alu_bus ();

    alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(2), .CAP_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_op      (prog_op),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .alu          (alu_bus),
        .pc           (pc),
        .last_y       (last_y),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ops D-F leave Y unchanged, LOAD writes A.
    logic [7:0] a_reg, y_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= 8'h00;
            y_reg <= 8'h00;
        end else if (alu_bus.alu_exec) begin
            case (alu_bus.alu_op_sel)
                OP_ADD:  y_reg <= a_reg + alu_bus.alu_input_bits;
                OP_SUB:  y_reg <= a_reg - alu_bus.alu_input_bits;
                OP_SHL:  y_reg <= {a_reg[6:0], 1'b0};
                OP_SHR:  y_reg <= {1'b0, a_reg[7:1]};
                OP_ROL:  y_reg <= {a_reg[6:0], a_reg[7]};
                OP_ROR:  y_reg <= {a_reg[0], a_reg[7:1]};
                OP_AND:  y_reg <= a_reg & alu_bus.alu_input_bits;
                OP_OR:   y_reg <= a_reg | alu_bus.alu_input_bits;
                OP_XOR:  y_reg <= a_reg ^ alu_bus.alu_input_bits;
                OP_NAND: y_reg <= ~(a_reg & alu_bus.alu_input_bits);
                OP_NOR:  y_reg <= ~(a_reg | alu_bus.alu_input_bits);
                OP_NOT:  y_reg <= ~a_reg;
                OP_INC:  y_reg <= a_reg + 8'h01;
                OP_NOP:  y_reg <= y_reg;
                OP_HOLD: y_reg <= y_reg;
                OP_LOAD: a_reg <= alu_bus.alu_input_bits;
                default: y_reg <= y_reg;
            endcase
        end
    end
    assign alu_bus.alu_y = y_reg;

    int         checks = 0;
    int         failures = 0;
    int         cyc, n_exec, n_done, n_rv, done_cyc;
    int         exec_cyc[$];
    logic [7:0] exp_y[$];
    logic [11:0] exp_cmd[$];
    logic       busy_after_abort;

    function automatic int exec_at(input int idx);
        return (idx < exec_cyc.size()) ? exec_cyc[idx] : -1000;
    endfunction

    task automatic write_entry(input int addr, input logic [3:0] op, input logic [7:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_op   = op;
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic launch(input int len);
        @(negedge clk);
        prog_len = (AW+1)'(len);
        start    = 1'b1;
    endtask

    task automatic finish_run();
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Runs n_cyc cycles, sampling on the falling edge and checking the
    // command and result scoreboards; optional abort / start glitch / write.
    task automatic watch(input int n_cyc, input int abort_cyc, input int glitch_cyc, input int we_cyc);
        logic [11:0] cmd_e;
        logic [7:0]  y_e;
        cyc = 0; n_exec = 0; n_done = 0; n_rv = 0; done_cyc = -1;
        busy_after_abort = 1'b1;
        exec_cyc.delete();
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge clk);
            cyc++;
            abort   = 1'b0;
            prog_we = 1'b0;
            if (cyc == abort_cyc + 1) busy_after_abort = busy;
            if (alu_bus.alu_exec) begin
                n_exec++;
                exec_cyc.push_back(cyc);
                checks++;
                if (exp_cmd.size() == 0) begin
                    failures++;
                    $display("FAIL cmd_unexpected cyc=%0d got=%h", cyc, {alu_bus.alu_op_sel, alu_bus.alu_input_bits});
                end else begin
                    cmd_e = exp_cmd.pop_front();
                    if ({alu_bus.alu_op_sel, alu_bus.alu_input_bits} !== cmd_e) begin
                        failures++;
                        $display("FAIL cmd cyc=%0d got=%h exp=%h", cyc, {alu_bus.alu_op_sel, alu_bus.alu_input_bits}, cmd_e);
                    end
                end
            end
            if (result_valid) begin
                n_rv++;
                checks++;
                if (exp_y.size() == 0) begin
                    failures++;
                    $display("FAIL result_unexpected cyc=%0d got=%h", cyc, last_y);
                end else begin
                    y_e = exp_y.pop_front();
                    if (last_y !== y_e) begin
                        failures++;
                        $display("FAIL last_y cyc=%0d got=%h exp=%h", cyc, last_y, y_e);
                    end
                end
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == abort_cyc) abort = 1'b1;
            if (cyc == glitch_cyc) start = 1'b0;
            if (glitch_cyc > 0 && cyc == glitch_cyc + 2) start = 1'b1;
            if (cyc == we_cyc) begin
                prog_we = 1'b1; prog_addr = '0; prog_op = OP_ADD; prog_data = 8'hFF;
            end
        end
        abort   = 1'b0;
        prog_we = 1'b0;
        checks++;
        if ((exp_y.size() + exp_cmd.size()) !== 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_y.size() + exp_cmd.size());
        end
        exp_y.delete();
        exp_cmd.delete();
    endtask

    task automatic load_three();
        write_entry(0, OP_LOAD, 8'h05);
        write_entry(1, OP_SHL,  8'h00);
        write_entry(2, OP_NOT,  8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_bus.alu_op_sel, alu_bus.alu_input_bits, alu_bus.alu_exec, pc, last_y,
             result_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {alu_bus.alu_op_sel, alu_bus.alu_input_bits,
                     alu_bus.alu_exec, pc, last_y, result_valid, busy, done});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_program();
        load_three();
        exp_cmd = '{12'hF05, 12'h200, 12'hB00};
        exp_y   = '{8'h00, 8'h0A, 8'hFA};
        launch(3);
        watch(22, 0, 0, 0);
        checks++; if (n_exec !== 3) begin failures++; $display("FAIL t1_exec_count got=%0d exp=3", n_exec); end
        checks++; if (exec_at(0) !== 4) begin failures++; $display("FAIL t1_first_exec got=%0d exp=4", exec_at(0)); end
        checks++; if (exec_at(1) - exec_at(0) !== 5) begin failures++; $display("FAIL t1_gap1 got=%0d exp=5", exec_at(1) - exec_at(0)); end
        checks++; if (exec_at(2) - exec_at(1) !== 5) begin failures++; $display("FAIL t1_gap2 got=%0d exp=5", exec_at(2) - exec_at(1)); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL t1_done_count got=%0d exp=1", n_done); end
        checks++; if (done_cyc !== exec_at(2) + 3) begin failures++; $display("FAIL t1_done_cyc got=%0d exp=%0d", done_cyc, exec_at(2) + 3); end
        checks++; if (n_rv !== 3) begin failures++; $display("FAIL t1_rv_count got=%0d exp=3", n_rv); end
        checks++; if (pc !== 3'd2) begin failures++; $display("FAIL t1_pc got=%0d exp=2", pc); end
        checks++; if (last_y !== 8'hFA) begin failures++; $display("FAIL t1_last_y got=%h exp=fa", last_y); end
        finish_run();
    endtask

    task automatic test_zero_len();
        launch(0);
        watch(6, 0, 0, 0);
        checks++; if (done_cyc !== 2) begin failures++; $display("FAIL t2_done_cyc got=%0d exp=2", done_cyc); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL t2_done_count got=%0d exp=1", n_done); end
        checks++; if (n_exec !== 0) begin failures++; $display("FAIL t2_exec_count got=%0d exp=0", n_exec); end
        checks++; if (last_y !== 8'hFA) begin failures++; $display("FAIL t2_last_y got=%h exp=fa", last_y); end
        finish_run();
    endtask

    task automatic test_abort();
        exp_cmd = '{12'hF05, 12'h200};
        exp_y   = '{8'hFA};
        launch(3);
        watch(16, 10, 0, 0);
        checks++; if (busy_after_abort !== 1'b0) begin failures++; $display("FAIL t3_idle_after_abort busy=%b exp=0", busy_after_abort); end
        checks++; if (pc !== 3'd1) begin failures++; $display("FAIL t3_pc got=%0d exp=1", pc); end
        checks++; if (n_rv !== 1) begin failures++; $display("FAIL t3_rv_count got=%0d exp=1", n_rv); end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL t3_done_count got=%0d exp=0", n_done); end
        checks++; if (last_y !== 8'hFA) begin failures++; $display("FAIL t3_last_y got=%h exp=fa", last_y); end
        finish_run();
        exp_cmd = '{12'hF05, 12'h200, 12'hB00};
        exp_y   = '{8'h0A, 8'h0A, 8'hFA};
        launch(3);
        watch(22, 0, 0, 0);
        checks++; if (exec_at(0) !== 4) begin failures++; $display("FAIL t3_rerun_first_exec got=%0d exp=4", exec_at(0)); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL t3_rerun_done got=%0d exp=1", n_done); end
        finish_run();
    endtask

    task automatic test_back_to_back();
        exp_cmd = '{12'hF05, 12'h200, 12'hB00};
        exp_y   = '{8'hFA, 8'h0A, 8'hFA};
        launch(3);
        watch(30, 0, 8, 6);
        checks++; if (n_exec !== 3) begin failures++; $display("FAIL t4_exec_count got=%0d exp=3", n_exec); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL t4_done_count got=%0d exp=1", n_done); end
        finish_run();
        exp_cmd = '{12'hF05, 12'h200, 12'hB00};
        exp_y   = '{8'hFA, 8'h0A, 8'hFA};
        launch(3);
        watch(22, 0, 0, 0);
        checks++; if (n_exec !== 3) begin failures++; $display("FAIL t4_rerun_exec got=%0d exp=3", n_exec); end
        finish_run();
    endtask

    task automatic test_reset_mid_run();
        bit found = 1'b0;
        launch(3);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (alu_bus.alu_exec) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL t5_exec_seen got=0 exp=1"); end
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (alu_bus.alu_exec !== 1'b0) begin failures++; $display("FAIL t5_exec_low got=%b exp=0", alu_bus.alu_exec); end
        checks++;
        if ({alu_bus.alu_op_sel, alu_bus.alu_input_bits, pc, last_y, result_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL t5_outputs got=%h exp=0", {alu_bus.alu_op_sel, alu_bus.alu_input_bits, pc, last_y, result_valid, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL t5_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_full_depth();
        write_entry(0, OP_LOAD, 8'h10);
        for (int i = 1; i < DEPTH; i++) write_entry(i, OP_ADD, 8'(i));
        for (int run = 0; run < 2; run++) begin
            exp_cmd.push_back(12'hF10);
            exp_y.push_back(run == 0 ? 8'h00 : 8'h17);
            for (int i = 1; i < DEPTH; i++) begin
                exp_cmd.push_back({OP_ADD, 8'(i)});
                exp_y.push_back(8'h10 + 8'(i));
            end
            launch(run == 0 ? 8 : 15);
            watch(48, 0, 0, 0);
            checks++; if (n_exec !== DEPTH) begin failures++; $display("FAIL t6_exec_count run=%0d got=%0d exp=8", run, n_exec); end
            checks++; if (pc !== 3'd7) begin failures++; $display("FAIL t6_pc run=%0d got=%0d exp=7", run, pc); end
            checks++; if (n_done !== 1) begin failures++; $display("FAIL t6_done run=%0d got=%0d exp=1", run, n_done); end
            checks++; if (last_y !== 8'h17) begin failures++; $display("FAIL t6_last_y run=%0d got=%h exp=17", run, last_y); end
            finish_run();
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_full_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
